// File: rtl/multi_port_freelist.sv
// Multi-port circular free list of physical IDs for rename.
// Hands out one ID per set request bit from head; packs returned IDs into tail.
module multi_port_freelist #(
    parameter  int unsigned SIZE = 32,
    parameter  int unsigned NA   = 4,
    parameter  int unsigned NF   = 4,
    localparam int unsigned W    = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NA-1:0]   i_alloc_req,
    output logic            o_alloc_rdy,
    output logic [NA*W-1:0] o_alloc_id,
    input  logic [NF-1:0]   i_free_vld,
    input  logic [NF*W-1:0] i_free_id,
    output logic [W:0]      o_free_cnt,
    output logic            o_overflow
);

    localparam int unsigned CW = W + 1;

    logic [W-1:0]  ram_q [SIZE];
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] alloc_n;
    logic [CW-1:0] alloc_take;
    logic [CW-1:0] avail;
    logic [CW-1:0] acc_n;
    logic          fire;
    logic          drop;
    logic [NF-1:0] wr_en;
    logic [W-1:0]  wr_addr [NF];

    // Allocation: each requesting port reads head offset by the requests below it.
    always_comb begin
        o_alloc_id = '0;
        alloc_n    = '0;
        for (int j = 0; j < int'(NA); j++) begin
            o_alloc_id[j*W +: W] = ram_q[head_q + W'(alloc_n)];
            if (i_alloc_req[j]) begin
                alloc_n = alloc_n + CW'(1);
            end
        end
    end

    assign o_alloc_rdy = (cnt_q >= CW'(NA));
    assign fire        = o_alloc_rdy & (|i_alloc_req);
    assign alloc_take  = fire ? alloc_n : '0;
    // Room for frees counts the slots vacated by this cycle's allocation.
    assign avail       = CW'(SIZE) - cnt_q + alloc_take;

    // Free packing: lowest-index valid frees fill the tail until capacity runs out.
    always_comb begin
        acc_n = '0;
        drop  = 1'b0;
        for (int j = 0; j < int'(NF); j++) begin
            wr_en[j]   = 1'b0;
            wr_addr[j] = tail_q + W'(acc_n);
            if (i_free_vld[j]) begin
                if (acc_n < avail) begin
                    wr_en[j] = 1'b1;
                    acc_n    = acc_n + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        head_d = head_q + W'(alloc_take);
        tail_d = tail_q + W'(acc_n);
        cnt_d  = cnt_q - alloc_take + acc_n;
        ovf_d  = ovf_q | drop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                ram_q[i] <= W'(i);
            end
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CW'(SIZE);
            ovf_q  <= 1'b0;
        end else begin
            for (int j = 0; j < int'(NF); j++) begin
                if (wr_en[j]) begin
                    ram_q[wr_addr[j]] <= i_free_id[j*W +: W];
                end
            end
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_free_cnt = cnt_q;
    assign o_overflow = ovf_q;

`ifndef SYNTHESIS
    // An accepted free must not match an ID still resident after this cycle's allocation.
    logic [NF-1:0] dup_c;
    always_comb begin
        logic [W-1:0]  off;
        logic [CW-1:0] live_n;
        dup_c  = '0;
        off    = '0;
        live_n = cnt_q - alloc_take;
        for (int j = 0; j < int'(NF); j++) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                off = W'(i) - (head_q + W'(alloc_take));
                if (wr_en[j] && (ram_q[i] == i_free_id[j*W +: W]) && (CW'(off) < live_n)) begin
                    dup_c[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (dup_c == '0)
                else $error("freed ID already resident in free list, ports %b", dup_c);
        end
    end
`endif

endmodule

// File: tb/tb_multi_port_freelist.sv
// Directed bench for multi_port_freelist: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_multi_port_freelist;

    localparam int unsigned SIZE = 32;
    localparam int unsigned NA   = 4;
    localparam int unsigned NF   = 4;
    localparam int unsigned W    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NA-1:0]   i_alloc_req;
    logic            o_alloc_rdy;
    logic [NA*W-1:0] o_alloc_id;
    logic [NF-1:0]   i_free_vld;
    logic [NF*W-1:0] i_free_id;
    logic [W:0]      o_free_cnt;
    logic            o_overflow;

    multi_port_freelist #(.SIZE(SIZE), .NA(NA), .NF(NF)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_alloc_req (i_alloc_req),
        .o_alloc_rdy (o_alloc_rdy),
        .o_alloc_id  (o_alloc_id),
        .i_free_vld  (i_free_vld),
        .i_free_id   (i_free_id),
        .o_free_cnt  (o_free_cnt),
        .o_overflow  (o_overflow)
    );

    always #5 clk = ~clk;

    typedef enum int {K_CNT, K_RDY, K_OVF, K_ID} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    idx;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int ex);
        n_checks++;
        if (act == ex) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, ex);
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                chk($sformatf("stale_exp@cyc%0d", e.cyc), cyc, e.cyc);
            end else begin
                case (e.kind)
                    K_CNT: chk($sformatf("free_cnt@cyc%0d", cyc), int'(o_free_cnt), e.val);
                    K_RDY: chk($sformatf("alloc_rdy@cyc%0d", cyc), int'(o_alloc_rdy), e.val);
                    K_OVF: chk($sformatf("overflow@cyc%0d", cyc), int'(o_overflow), e.val);
                    default: chk($sformatf("alloc_id[%0d]@cyc%0d", e.idx, cyc),
                                 int'(o_alloc_id[e.idx*W +: W]), e.val);
                endcase
            end
        end
    end

    task automatic push(input kind_e k, input int idx, input int val);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.idx  = idx;
        e.val  = val;
        sbq.push_back(e);
    endtask

    task automatic exp_ids(input int a, input int b, input int c, input int d);
        push(K_ID, 0, a);
        push(K_ID, 1, b);
        push(K_ID, 2, c);
        push(K_ID, 3, d);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] fv,
                         input int f0, input int f1, input int f2, input int f3);
        i_alloc_req = req;
        i_free_vld  = fv;
        i_free_id   = {W'(f3), W'(f2), W'(f1), W'(f0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        tick();
        push(K_CNT, 0, 32); push(K_RDY, 0, 1); push(K_OVF, 0, 0);
        tick();
        rst = 1'b1;

        // Full-width allocation from a fresh list.
        do_reset();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        exp_ids(0, 1, 2, 3); push(K_CNT, 0, 32); push(K_RDY, 0, 1);
        tick();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        exp_ids(4, 5, 6, 7); push(K_CNT, 0, 28);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 24);
        tick();

        // Sparse request mask.
        do_reset();
        drive(4'b1010, 4'b0000, 0, 0, 0, 0);
        push(K_ID, 1, 0); push(K_ID, 3, 1);
        tick();
        drive(4'b0001, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 30); push(K_ID, 0, 2);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 29);
        tick();

        // Not-ready: request ignored until a free raises the count.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(4'b1111, 4'b0000, 0, 0, 0, 0);
            tick();
        end
        drive(4'b0001, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 4); push(K_RDY, 0, 1); push(K_ID, 0, 28);
        tick();
        drive(4'b0001, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 3); push(K_RDY, 0, 0);
        tick();
        drive(4'b0001, 4'b0001, 0, 0, 0, 0);
        push(K_CNT, 0, 3); push(K_RDY, 0, 0);
        tick();
        drive(4'b0001, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 4); push(K_RDY, 0, 1); push(K_ID, 0, 29);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 3);
        tick();

        // Sparse free packing and FIFO reissue order.
        do_reset();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        tick();
        drive(4'b0000, 4'b0101, 2, 0, 0, 0);
        push(K_CNT, 0, 28);
        tick();
        push(K_CNT, 0, 30);
        for (int i = 0; i < 7; i++) begin
            drive(4'b1111, 4'b0000, 0, 0, 0, 0);
            exp_ids(4 + 4*i, 5 + 4*i, 6 + 4*i, 7 + 4*i);
            tick();
        end
        drive(4'b0000, 4'b0011, 4, 5, 0, 0);
        push(K_CNT, 0, 2); push(K_RDY, 0, 0);
        tick();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 4); exp_ids(2, 0, 4, 5);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 0); push(K_RDY, 0, 0);
        tick();

        // Simultaneous alloc/free with no bypass, then head wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 0, 0, 0, 0);
            tick();
        end
        drive(4'b0011, 4'b0000, 0, 0, 0, 0);
        tick();
        drive(4'b1111, 4'b1100, 0, 0, 5, 9);
        push(K_CNT, 0, 10); exp_ids(22, 23, 24, 25);
        tick();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 8); exp_ids(26, 27, 28, 29);
        tick();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 4); exp_ids(30, 31, 5, 9);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 0); push(K_RDY, 0, 0);
        tick();

        // Capacity boundary, overflow, sticky flag and async reset.
        do_reset();
        drive(4'b1111, 4'b1111, 0, 1, 2, 3);
        exp_ids(0, 1, 2, 3); push(K_CNT, 0, 32);
        tick();
        drive(4'b0011, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 32); push(K_OVF, 0, 0); push(K_ID, 0, 4); push(K_ID, 1, 5);
        tick();
        drive(4'b0000, 4'b1111, 4, 5, 20, 21);
        push(K_CNT, 0, 30); push(K_OVF, 0, 0);
        tick();
        drive(4'b0000, 4'b0011, 5, 6, 0, 0);
        push(K_CNT, 0, 32); push(K_OVF, 0, 1);
        tick();
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 32); push(K_OVF, 0, 1);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 28); push(K_OVF, 0, 1);
        tick();
        #2;
        rst = 1'b0;
        push(K_CNT, 0, 32); push(K_OVF, 0, 0); push(K_RDY, 0, 1);
        tick();
        rst = 1'b1;
        drive(4'b1111, 4'b0000, 0, 0, 0, 0);
        exp_ids(0, 1, 2, 3); push(K_CNT, 0, 32);
        tick();
        drive(4'b0000, 4'b0000, 0, 0, 0, 0);
        push(K_CNT, 0, 28);
        tick();

        repeat (3) tick();
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_checks++;
            $display("FAIL unchecked_exp: queued for cyc %0d, still pending at cyc %0d", e.cyc, cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
